// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, redirect input and decode handshake.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, buffers fetched words in a small queue for decode.
// Optional self-halt on HALT_WORD enabled by defining FETCH_HALT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } entry_t;

`ifdef FETCH_HALT_EN
  typedef enum logic {S_RUN, S_HALT} state_e;
`else
  typedef enum logic [0:0] {S_RUN} state_e;
`endif

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  entry_t             queue_q [QDEPTH];
  entry_t             queue_d [QDEPTH];
  logic               enq_c;
  logic               deq_c;
  logic [31:0]        pc_plus4_c;
  entry_t             head_c;
`ifdef FETCH_HALT_EN
  logic               halted_q, halted_d;
`else
  logic               unused_c;
  assign unused_c = ^{HALT_WORD, bus.redirect_pc[1:0]};
`endif

  // State and queue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      queue_q    <= '{default: '0};
`ifdef FETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      queue_q    <= queue_d;
`ifdef FETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  assign pc_plus4_c = fetch_pc_q + 32'd4;

  // Next-state: redirect flushes everything, otherwise enqueue/dequeue
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    queue_d    = queue_q;
`ifdef FETCH_HALT_EN
    halted_d   = halted_q;
`endif
    deq_c = (count_q != '0) && bus.id_ready;
    enq_c = (state_q == S_RUN) && ((count_q < CNT_W'(QDEPTH)) || deq_c);

    if (bus.redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      state_d    = S_RUN;
`ifdef FETCH_HALT_EN
      halted_d   = 1'b0;
`endif
    end else begin
      if (enq_c) begin
        queue_d[tail_q] = '{pc: fetch_pc_q, pc_plus4: pc_plus4_c, instr: bus.imem_data};
        tail_d          = PTR_W'(tail_q + 1'b1);
        fetch_pc_d      = pc_plus4_c;
`ifdef FETCH_HALT_EN
        if (bus.imem_data == HALT_WORD) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end
`endif
      end
      if (deq_c) begin
        head_d = PTR_W'(head_q + 1'b1);
      end
      count_d = CNT_W'(count_q + CNT_W'(enq_c) - CNT_W'(deq_c));
    end
  end

  // Decode-facing view of the queue head; zeroed while empty
  assign head_c          = queue_q[head_q];
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.id_valid    = (count_q != '0);
  assign bus.id_instr    = bus.id_valid ? head_c.instr    : '0;
  assign bus.id_pc       = bus.id_valid ? head_c.pc       : '0;
  assign bus.id_pc_plus4 = bus.id_valid ? head_c.pc_plus4 : '0;
`ifdef FETCH_HALT_EN
  assign bus.halted      = halted_q;
`else
  assign bus.halted      = 1'b0;
`endif

endmodule
